// File: rtl/udp_reg_ring_master.sv
// ============================================================================
// Module   : udp_reg_ring_master
// Brief    : Initiator end of the user-data-path register ring. Launches one
//            host register transaction at a time onto the ring, matches the
//            returning request by source tag, and reports ack / read data /
//            error / timeout back to the host.
// Options  : define UDP_REG_MASTER_STATS_EN to add saturating completion,
//            timeout and stray-return counters (stat_done, stat_timeout,
//            stat_stray).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT_CYCLES    = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  // host side
  input  logic                                host_req,
  input  logic                                host_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]      host_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     host_wr_data,
  output logic                                host_busy,
  output logic                                host_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]     host_rd_data,
  output logic                                host_err,
  output logic                                host_timeout,
  // ring launch
  output logic                                reg_req_out,
  output logic                                reg_ack_out,
  output logic                                reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,
  // ring return
  input  logic                                reg_req_in,
  input  logic                                reg_ack_in,
  input  logic                                reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in
`ifdef UDP_REG_MASTER_STATS_EN
  ,
  output logic [15:0]                         stat_done,
  output logic [15:0]                         stat_timeout,
  output logic [15:0]                         stat_stray
`endif
);

  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam int AW = `UDP_REG_ADDR_WIDTH;

  localparam logic [DW-1:0]                ERR_DATA   = DW'(32'hDEAD_BEEF);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG    = UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [15:0]                  TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                         state_q;
  logic [15:0]                    timer_q;
  logic                           busy_q;
  logic                           ack_q;
  logic [DW-1:0]                  rd_data_q;
  logic                           err_q;
  logic                           timeout_q;
  logic                           req_out_q;
  logic                           ack_out_q;
  logic                           rd_wr_L_out_q;
  logic [AW-1:0]                  addr_out_q;
  logic [DW-1:0]                  data_out_q;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_out_q;

  // Return address and direction are not needed: one request is outstanding,
  // so the source tag alone identifies it.
  logic unused_ring_fields;
  assign unused_ring_fields = ^{reg_rd_wr_L_in, reg_addr_in};

  logic ret_match;
  logic timer_expired;
  assign ret_match     = reg_req_in && (reg_src_in == SRC_TAG);
  assign timer_expired = (timer_q == TIMER_LAST);

  // Transaction FSM; the ring launch registers double as the latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      rd_data_q     <= '0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      req_out_q     <= 1'b0;
      ack_out_q     <= 1'b0;
      rd_wr_L_out_q <= 1'b0;
      addr_out_q    <= '0;
      data_out_q    <= '0;
      src_out_q     <= '0;
    end else begin
      // Pulses and ring launch fields are only non-zero for one cycle.
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      req_out_q     <= 1'b0;
      ack_out_q     <= 1'b0;
      rd_wr_L_out_q <= 1'b0;
      addr_out_q    <= '0;
      data_out_q    <= '0;
      src_out_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (host_req) begin
            state_q       <= ST_ISSUE;
            busy_q        <= 1'b1;
            req_out_q     <= 1'b1;
            rd_wr_L_out_q <= host_rd_wr_L;
            addr_out_q    <= host_addr;
            data_out_q    <= host_wr_data;
            src_out_q     <= SRC_TAG;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          timer_q <= '0;
        end
        ST_WAIT: begin
          // A return in the same cycle as expiry takes priority.
          if (ret_match) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= ~reg_ack_in;
            rd_data_q <= reg_ack_in ? reg_data_in : ERR_DATA;
          end else if (timer_expired) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            rd_data_q <= ERR_DATA;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host_busy       = busy_q;
  assign host_ack        = ack_q;
  assign host_rd_data    = rd_data_q;
  assign host_err        = err_q;
  assign host_timeout    = timeout_q;
  assign reg_req_out     = req_out_q;
  assign reg_ack_out     = ack_out_q;
  assign reg_rd_wr_L_out = rd_wr_L_out_q;
  assign reg_addr_out    = addr_out_q;
  assign reg_data_out    = data_out_q;
  assign reg_src_out     = src_out_q;

`ifdef UDP_REG_MASTER_STATS_EN
  logic        done_hit;
  logic        timeout_hit;
  logic        stray_hit;
  logic [15:0] done_q;
  logic [15:0] timeout_cnt_q;
  logic [15:0] stray_q;

  assign done_hit    = (state_q == ST_WAIT) && ret_match && reg_ack_in;
  assign timeout_hit = (state_q == ST_WAIT) && !ret_match && timer_expired;
  assign stray_hit   = (state_q != ST_WAIT) && ret_match;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q        <= '0;
      timeout_cnt_q <= '0;
      stray_q       <= '0;
    end else begin
      if (done_hit && (done_q != 16'hFFFF))
        done_q <= done_q + 16'd1;
      if (timeout_hit && (timeout_cnt_q != 16'hFFFF))
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      if (stray_hit && (stray_q != 16'hFFFF))
        stray_q <= stray_q + 16'd1;
    end
  end

  assign stat_done    = done_q;
  assign stat_timeout = timeout_cnt_q;
  assign stat_stray   = stray_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_reg_ring_master.sv
// ============================================================================
// Module   : tb_udp_reg_ring_master
// Brief    : Self-checking bench for udp_reg_ring_master: a 2-stage ring
//            model with a claiming responder, return injection, and a
//            scoreboard of expected host completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [31:0] RD_VAL = 32'hCAFE_F00D;
  localparam logic [31:0] ERRV   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_req = 1'b0;
  logic          host_rd_wr_L = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_busy, host_ack, host_err, host_timeout;
  logic [DW-1:0] host_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [1:0]    reg_src_in;
`ifdef UDP_REG_MASTER_STATS_EN
  logic [15:0]   stat_done, stat_timeout, stat_stray;
`endif

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH (2),
    .SRC_ID            (0),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host_req        (host_req),
    .host_rd_wr_L    (host_rd_wr_L),
    .host_addr       (host_addr),
    .host_wr_data    (host_wr_data),
    .host_busy       (host_busy),
    .host_ack        (host_ack),
    .host_rd_data    (host_rd_data),
    .host_err        (host_err),
    .host_timeout    (host_timeout),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in)
`ifdef UDP_REG_MASTER_STATS_EN
    ,
    .stat_done       (stat_done),
    .stat_timeout    (stat_timeout),
    .stat_stray      (stat_stray)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- ring model ----------------
  // mode 0: responder claims (ack=1, read data RD_VAL); 1: unclaimed; 2: dropped
  int            mode = 0;
  logic          s1_req = 0, s1_ack = 0, s1_rw = 0;
  logic [AW-1:0] s1_addr = '0;
  logic [DW-1:0] s1_data = '0;
  logic [1:0]    s1_src = '0;
  logic          s2_req = 0, s2_ack = 0, s2_rw = 0;
  logic [AW-1:0] s2_addr = '0;
  logic [DW-1:0] s2_data = '0;
  logic [1:0]    s2_src = '0;

  always @(posedge clk) begin
    s1_req  <= reg_req_out && (mode != 2);
    s1_ack  <= reg_ack_out || (reg_req_out && mode == 0);
    s1_rw   <= reg_rd_wr_L_out;
    s1_addr <= reg_addr_out;
    s1_data <= (reg_req_out && mode == 0 && reg_rd_wr_L_out) ? RD_VAL : reg_data_out;
    s1_src  <= reg_src_out;
    s2_req  <= s1_req;
    s2_ack  <= s1_ack;
    s2_rw   <= s1_rw;
    s2_addr <= s1_addr;
    s2_data <= s1_data;
    s2_src  <= s1_src;
  end

  // direct return injection overrides the ring pipeline
  logic          inj_en = 0, inj_ack = 0;
  logic [DW-1:0] inj_data = '0;
  logic [1:0]    inj_src = '0;

  assign reg_req_in     = inj_en ? 1'b1     : s2_req;
  assign reg_ack_in     = inj_en ? inj_ack  : s2_ack;
  assign reg_rd_wr_L_in = inj_en ? 1'b1     : s2_rw;
  assign reg_addr_in    = inj_en ? '0       : s2_addr;
  assign reg_data_in    = inj_en ? inj_data : s2_data;
  assign reg_src_in     = inj_en ? inj_src  : s2_src;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;
  exp_t exp_q[$];
  int   acks = 0;

  always @(negedge clk) begin
    if (!reset && host_ack) begin
      acks++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_rd_data", host_rd_data, e.data);
        check("sb_err", host_err, e.err);
        check("sb_timeout", host_timeout, e.to);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drives one host request, pushes its expectation, and checks the launch
  // cycle; returns at the negedge after the launch edge (k = 1).
  task automatic drive(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [31:0] e_data, input logic e_err, input logic e_to);
    exp_t e;
    @(negedge clk);
    host_req = 1'b1; host_rd_wr_L = rd; host_addr = addr; host_wr_data = data;
    e.data = e_data; e.err = e_err; e.to = e_to;
    exp_q.push_back(e);
    @(negedge clk);
    host_req = 1'b0;
    check("launch_req", reg_req_out, 1);
    check("launch_ack", reg_ack_out, 0);
    check("launch_src", reg_src_out, 0);
    check("launch_rw", reg_rd_wr_L_out, rd);
    check("launch_addr", reg_addr_out, addr);
    check("launch_data", reg_data_out, data);
    check("launch_busy", host_busy, 1);
  endtask

  // Waits (bounded) for host_ack; lat is negedges since the drive negedge.
  task automatic wait_ack(input int k0, output int lat);
    int k = k0;
    while (!host_ack && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!host_ack) check("ack_wait_expired", 0, 1);
    else           check("busy_at_ack", host_busy, 0);
    lat = k;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    int a0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {host_busy, host_ack, host_rd_data, host_err, host_timeout, reg_req_out,
           reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 0);
    reset = 1'b0;
    @(negedge clk);

    // write, claimed by responder
    mode = 0;
    drive(1'b0, 23'h000040, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    @(negedge clk);
    check("issue_cleared", {reg_req_out, reg_addr_out, reg_data_out, reg_src_out, reg_rd_wr_L_out}, 0);
    wait_ack(2, lat);
    check("write_latency", lat, 4);

    // read, claimed
    drive(1'b1, 23'h000044, 32'h0, RD_VAL, 1'b0, 1'b0);
    wait_ack(1, lat);
    check("read_latency", lat, 4);

    // unclaimed
    mode = 1;
    drive(1'b1, 23'h000080, 32'h0, ERRV, 1'b1, 1'b0);
    wait_ack(1, lat);
    check("unclaimed_latency", lat, 4);

    // dropped -> timeout 8 cycles after WAIT entry (WAIT entered at k = 2)
    mode = 2;
    drive(1'b0, 23'h000090, 32'h0000_AAAA, ERRV, 1'b1, 1'b1);
    wait_ack(1, lat);
    check("timeout_latency", lat, 10);
    @(negedge clk);
    check("ack_is_pulse", host_ack, 0);
    check("rd_data_held", host_rd_data, ERRV);

    // foreign return and second host_req ignored during WAIT
    a0 = acks;
    drive(1'b1, 23'h000048, 32'h0, 32'h55AA_55AA, 1'b0, 1'b0);
    @(negedge clk);
    inj_en = 1; inj_ack = 1; inj_src = 2'd2; inj_data = 32'h1111_1111;
    host_req = 1; host_rd_wr_L = 0; host_addr = 23'h000050; host_wr_data = 32'h9999_9999;
    @(negedge clk);
    inj_en = 0; host_req = 0;
    check("foreign_no_ack", host_ack, 0);
    check("busy_req_ignored", reg_req_out, 0);
    @(negedge clk);
    check("foreign_no_ack2", host_ack, 0);
    inj_en = 1; inj_ack = 1; inj_src = 2'd0; inj_data = 32'h55AA_55AA;
    @(negedge clk);
    inj_en = 0;
    check("true_return_ack", host_ack, 1);
    repeat (14) @(negedge clk);
    check("single_completion", acks - a0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef UDP_REG_MASTER_STATS_EN
    check("stat_done_pre", stat_done, 3);
    check("stat_timeout_pre", stat_timeout, 1);
    check("stat_stray_pre", stat_stray, 0);
`endif

    // reset mid-WAIT
    mode = 2;
    a0 = acks;
    drive(1'b0, 23'h00004C, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          {host_busy, host_ack, host_rd_data, host_err, host_timeout, reg_req_out,
           reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    inj_en = 1; inj_ack = 1; inj_src = 2'd0; inj_data = 32'h4444_4444;
    @(negedge clk);
    inj_en = 0;
    repeat (3) @(negedge clk);
    check("late_return_ignored", acks - a0, 0);
    check("late_return_idle", host_busy, 0);
`ifdef UDP_REG_MASTER_STATS_EN
    check("stat_stray", stat_stray, 1);
`endif

    // normal write after reset
    mode = 0;
    drive(1'b0, 23'h000040, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0);
    wait_ack(1, lat);
    check("post_reset_latency", lat, 4);
    repeat (2) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);
`ifdef UDP_REG_MASTER_STATS_EN
    check("stat_done_post", stat_done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
